// File: rtl/tff_toggle_gen.sv
// ---------------------------------------------------------------------------
// tff_toggle_gen
//
// Produces single-cycle toggle-enable pulses (t) for a downstream T
// flip-flop. A start in IDLE captures the period and burst length. In RUN
// a pulse is issued every per_q+1 enabled cycles. A non-zero burst length
// ends the run after that many pulses, passing through a one-cycle DONE
// state that carries the last pulse. en pauses the count, stop aborts.
//
// Handshake: there is no valid/ready pair. start is a level sampled only
// in IDLE, and stop is a level sampled only in RUN. Neither is
// acknowledged; busy tells the requester whether a run is in progress.
//
// Ports
//   clk        in   rising-edge clock
//   clear_n    in   asynchronous active-low reset
//   start      in   launch request (IDLE only)
//   stop       in   abort (RUN only, beats a pulse due on the same edge)
//   en         in   count enable; 0 pauses the counter in RUN
//   period     in   pulse spacing minus 1, captured on start
//   burst_len  in   pulses per burst, 0 = continuous, captured on start
//   t          out  toggle enable to the TFF stage
//   busy       out  high in RUN and DONE
//   done       out  one-cycle flag on the final burst pulse
//   tog_cnt    out  pulses since the last start (wraps when continuous)
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module tff_toggle_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               t,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tog_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] tog_d;
    logic               t_d, done_d, busy_d;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            cnt     <= '0;
            per_q   <= '0;
            burst_q <= '0;
            tog_cnt <= '0;
            t       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            per_q   <= per_d;
            burst_q <= burst_d;
            tog_cnt <= tog_d;
            t       <= t_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        per_d   = per_q;
        burst_d = burst_q;
        tog_d   = tog_cnt;
        t_d     = 1'b0;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                // start wins over stop here; stop means nothing in IDLE.
                if (start) begin
                    per_d   = period;
                    burst_d = burst_len;
                    cnt_d   = '0;
                    tog_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort drops any pulse due on this edge; counts hold.
                    state_d = IDLE;
                end else if (en) begin
                    if (cnt == per_q) begin
                        t_d   = 1'b1;
                        cnt_d = '0;
                        tog_d = tog_cnt + 1'b1;
                        // Last pulse of a finite burst rides out in DONE.
                        if ((burst_q != '0) && (tog_d == burst_q)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_tff_toggle_gen.sv
module tb_tff_toggle_gen;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start, stop, en;
    logic [7:0] period;
    logic [3:0] burst_len;
    logic       t, busy, done;
    logic [3:0] tog_cnt;
    logic       q;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    tff_toggle_gen #(.CNT_W(8), .BURST_W(4)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .period    (period),
        .burst_len (burst_len),
        .t         (t),
        .busy      (busy),
        .done      (done),
        .tog_cnt   (tog_cnt)
    );

    // Downstream T flip-flop driven by t.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) q <= 1'b0;
        else          q <= q ^ t;
    end

    // ---------------- reference model ----------------
    // Counts enabled cycles since start: a pulse lands whenever that count
    // is a multiple of (period+1). The pulse number decides tog_cnt and done.
    bit m_active, m_done_phase;
    int m_per, m_burst, m_en_cycles, m_pulses;
    bit m_t, m_busy, m_done, m_q;
    int m_tog;

    task automatic model_reset();
        m_active = 0; m_done_phase = 0;
        m_per = 0; m_burst = 0; m_en_cycles = 0; m_pulses = 0;
        m_t = 0; m_busy = 0; m_done = 0; m_tog = 0; m_q = 0;
    endtask

    task automatic model_step();
        m_q ^= m_t;
        m_t = 0;
        m_done = 0;
        if (m_done_phase) begin
            m_done_phase = 0;
            m_active = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_per = int'(period);
                m_burst = int'(burst_len);
                m_en_cycles = 0;
                m_pulses = 0;
                m_tog = 0;
            end
        end else if (stop) begin
            m_active = 0;
        end else if (en) begin
            m_en_cycles++;
            if (m_en_cycles % (m_per + 1) == 0) begin
                m_pulses++;
                m_t = 1;
                m_tog = m_pulses % 16;
                if (m_burst != 0 && m_pulses == m_burst) begin
                    m_done = 1;
                    m_done_phase = 1;
                end
            end
        end
        m_busy = m_active;
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the same edge; outputs are sampled 1 time
    // unit later, then the caller may change inputs.
    task automatic cycle();
        @(posedge clk);
        if (!clear_n) model_reset();
        else          model_step();
        #1;
    endtask

    // Scoreboard: the model's expected output word is queued and compared
    // against the DUT after the same edge.
    logic [7:0] exp_q[$];

    task automatic check_model(input string tag);
        logic [7:0] e;
        exp_q.push_back({m_q, m_t, m_busy, m_done, m_tog[3:0]});
        e = exp_q.pop_front();
        chk({tag, ".t"},    int'(t),       int'(e[6]));
        chk({tag, ".busy"}, int'(busy),    int'(e[5]));
        chk({tag, ".done"}, int'(done),    int'(e[4]));
        chk({tag, ".tog"},  int'(tog_cnt), int'(e[3:0]));
        chk({tag, ".q"},    int'(q),       int'(e[7]));
    endtask

    task automatic drive(input logic s, input logic sp, input logic e,
                         input logic [7:0] p, input logic [3:0] b);
        start = s; stop = sp; en = e; period = p; burst_len = b;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       start, stop, en;
        logic [7:0] period;
        logic [3:0] burst_len;
        logic       exp_t, exp_busy, exp_done;
        logic [3:0] exp_tog;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic s, input logic sp, input logic e,
                       input logic [7:0] p, input logic [3:0] b,
                       input logic xt, input logic xb, input logic xd,
                       input logic [3:0] xg, input int reps);
        vec_t v;
        v.start = s; v.stop = sp; v.en = e; v.period = p; v.burst_len = b;
        v.exp_t = xt; v.exp_busy = xb; v.exp_done = xd; v.exp_tog = xg;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    initial begin
        model_reset();
        clear_n = 1'b0;
        drive(0, 0, 0, 8'd0, 4'd0);

        // Burst of 3 with period=1: pulses after E+2, E+4, E+6, done on E+6.
        add(1, 0, 1, 8'd1, 4'd3, 0, 1, 0, 4'd0, 1); // E
        add(0, 0, 1, 8'd9, 4'd7, 0, 1, 0, 4'd0, 1); // E+1 (new period ignored)
        add(1, 0, 1, 8'd9, 4'd7, 1, 1, 0, 4'd1, 1); // E+2 (start ignored)
        add(0, 0, 1, 8'd1, 4'd3, 0, 1, 0, 4'd1, 1); // E+3
        add(0, 0, 1, 8'd1, 4'd3, 1, 1, 0, 4'd2, 1); // E+4
        add(0, 0, 1, 8'd1, 4'd3, 0, 1, 0, 4'd2, 1); // E+5
        add(0, 0, 1, 8'd1, 4'd3, 1, 1, 1, 4'd3, 1); // E+6
        add(1, 0, 1, 8'd1, 4'd3, 0, 0, 0, 4'd3, 1); // E+7 (start in DONE ignored)
        add(0, 1, 1, 8'd1, 4'd3, 0, 0, 0, 4'd3, 1); // idle, stop no effect
        // period=4, burst=5, stop on the edge of the 2nd pulse.
        add(1, 1, 1, 8'd4, 4'd5, 0, 1, 0, 4'd0, 1); // E (start beats stop)
        add(0, 0, 1, 8'd4, 4'd5, 0, 1, 0, 4'd0, 4); // E+1..E+4
        add(0, 0, 1, 8'd4, 4'd5, 1, 1, 0, 4'd1, 1); // E+5
        add(0, 0, 1, 8'd4, 4'd5, 0, 1, 0, 4'd1, 4); // E+6..E+9
        add(0, 1, 1, 8'd4, 4'd5, 0, 0, 0, 4'd1, 1); // E+10 stop wins
        add(0, 0, 1, 8'd4, 4'd5, 0, 0, 0, 4'd1, 2); // idle, held

        // 1: reset held with start toggling.
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            period = 8'd0;
            cycle();
            chk("rst.t", int'(t), 0);
            chk("rst.busy", int'(busy), 0);
            chk("rst.done", int'(done), 0);
            chk("rst.tog", int'(tog_cnt), 0);
        end
        start = 0;
        #2 clear_n = 1'b1;

        // Table-driven directed vectors (tests 3 and 5).
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].en,
                  vecs[i].period, vecs[i].burst_len);
            cycle();
            chk($sformatf("vec%0d.t", i),    int'(t),       int'(vecs[i].exp_t));
            chk($sformatf("vec%0d.busy", i), int'(busy),    int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d.done", i), int'(done),    int'(vecs[i].exp_done));
            chk($sformatf("vec%0d.tog", i),  int'(tog_cnt), int'(vecs[i].exp_tog));
        end

        // 2: period=3 continuous: pulses after E+4, E+8, E+12.
        drive(1, 0, 1, 8'd3, 4'd0);
        cycle(); check_model("cont");
        start = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(); check_model("cont");
            chk("cont.pulse", int'(t), (k % 4 == 0) ? 1 : 0);
        end
        chk("cont.tog3", int'(tog_cnt), 3);
        stop = 1; cycle(); check_model("cont_stop");
        stop = 0;

        // 4: period=0 continuous, TFF toggles each clock; en pause; wrap.
        drive(1, 0, 1, 8'd0, 4'd0);
        cycle(); check_model("p0");
        start = 0;
        for (int k = 1; k <= 20; k++) begin
            en = !(k == 6 || k == 7);
            cycle(); check_model("p0");
        end
        chk("p0.wrap", int'(tog_cnt), 18 % 16);
        stop = 1; cycle(); check_model("p0_stop");
        stop = 0;

        // 6: clear_n mid-burst, then clean restart with a one-pulse burst.
        drive(1, 0, 1, 8'd2, 4'd3);
        cycle(); start = 0;
        for (int k = 0; k < 4; k++) begin cycle(); check_model("pre_clr"); end
        clear_n = 1'b0;
        model_reset();
        #2;
        check_model("clr_async");
        cycle(); check_model("clr_held");
        #2 clear_n = 1'b1;
        drive(1, 0, 1, 8'd2, 4'd1);
        cycle(); check_model("restart");
        start = 0;
        cycle(); cycle();
        chk("restart.early_t", int'(t), 0);
        cycle();
        chk("restart.t", int'(t), 1);
        chk("restart.done", int'(done), 1);
        chk("restart.tog", int'(tog_cnt), 1);
        cycle();
        chk("restart.idle", int'(busy), 0);
        check_model("restart_end");

        // Randomized stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 9) < 3);
            stop      = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 9) < 8);
            period    = 8'($urandom_range(0, 5));
            burst_len = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                clear_n = 1'b0;
                model_reset();
                #1 check_model("rnd_clr");
                #1 clear_n = 1'b1;
            end
            cycle();
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
